// File: rtl/mips_pkg.sv
// =====================================================================
// Module   : mips_pkg
// Desc     : Shared MIPS definitions: register-file default widths and
//            the debug-dump FSM state encoding.
// Revision : 1.0 - initial release
// =====================================================================
`default_nettype none

package mips_pkg;

    localparam int c_NB_REG      = 32;
    localparam int c_NB_REG_ADDR = 5;

    localparam int c_DUMP_ST_W = 2;
    typedef logic [c_DUMP_ST_W-1:0] dump_state_t;

    localparam dump_state_t c_ST_IDLE = 2'd0;
    localparam dump_state_t c_ST_DUMP = 2'd1;
    localparam dump_state_t c_ST_DONE = 2'd2;

endpackage : mips_pkg

`default_nettype wire

// File: rtl/regfile_dump_ctrl.sv
// =====================================================================
// Module   : regfile_dump_ctrl
// Desc     : Debug dump sequencer; walks the register index 0..DEPTH-1
//            under a valid/ready handshake and pulses done at the end.
// Revision : 1.0 - initial release
// =====================================================================
`default_nettype none

module regfile_dump_ctrl
    import mips_pkg::*;
#(
    parameter int NB_REG_ADDR = c_NB_REG_ADDR
) (
    input  logic                   i_clock,
    input  logic                   i_reset,
    input  logic                   i_dump_start,
    input  logic                   i_dump_ready,
    output logic [NB_REG_ADDR-1:0] o_index,
    output logic                   o_valid,
    output logic                   o_done
);

    localparam logic [NB_REG_ADDR-1:0] c_LAST_IDX = {NB_REG_ADDR{1'b1}};

    dump_state_t             state_q;
    dump_state_t             state_d;
    logic [NB_REG_ADDR-1:0]  index_q;
    logic [NB_REG_ADDR-1:0]  index_d;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q <= c_ST_IDLE;
            index_q <= '0;
        end else begin
            state_q <= state_d;
            index_q <= index_d;
        end
    end

    always_comb begin
        state_d = state_q;
        index_d = index_q;
        case (state_q)
            c_ST_IDLE: begin
                if (i_dump_start) begin
                    state_d = c_ST_DUMP;
                    index_d = '0;
                end
            end
            c_ST_DUMP: begin
                // Last index terminates the walk instead of wrapping to 0.
                if (i_dump_ready) begin
                    if (index_q == c_LAST_IDX) begin
                        state_d = c_ST_DONE;
                    end else begin
                        index_d = index_q + 1'b1;
                    end
                end
            end
            c_ST_DONE: begin
                state_d = c_ST_IDLE;
                index_d = '0;
            end
            default: begin
                state_d = c_ST_IDLE;
                index_d = '0;
            end
        endcase
    end

    always_comb begin
        o_valid = 1'b0;
        o_done  = 1'b0;
        case (state_q)
            c_ST_DUMP: o_valid = 1'b1;
            c_ST_DONE: o_done  = 1'b1;
            default: begin
                o_valid = 1'b0;
                o_done  = 1'b0;
            end
        endcase
    end

    assign o_index = index_q;

endmodule : regfile_dump_ctrl

`default_nettype wire

// File: rtl/register_file.sv
// =====================================================================
// Module   : register_file
// Desc     : MIPS general-purpose register file, two read ports, one
//            write-back port and a debug dump stream. Defining macro
//            REGFILE_BYPASS_EN adds same-cycle write-to-read forwarding.
// Revision : 1.0 - initial release
// =====================================================================
`default_nettype none

module register_file
    import mips_pkg::*;
#(
    parameter int NB_REG      = c_NB_REG,
    parameter int NB_REG_ADDR = c_NB_REG_ADDR
) (
    input  logic                   i_clock,
    input  logic                   i_reset,
    input  logic [NB_REG-1:0]      i_wb_data,
    input  logic [NB_REG_ADDR-1:0] i_reg_dest,
    input  logic                   i_reg_we,
    input  logic [NB_REG_ADDR-1:0] i_rs_addr,
    input  logic [NB_REG_ADDR-1:0] i_rt_addr,
    output logic [NB_REG-1:0]      o_rs_data,
    output logic [NB_REG-1:0]      o_rt_data,
    input  logic                   i_dump_start,
    input  logic                   i_dump_ready,
    output logic                   o_dump_valid,
    output logic [NB_REG_ADDR-1:0] o_dump_addr,
    output logic [NB_REG-1:0]      o_dump_data,
    output logic                   o_dump_done
);

    localparam int c_DEPTH = 2 ** NB_REG_ADDR;

    logic [NB_REG-1:0]      regs_q [c_DEPTH];
    logic                   w_wr_en;
    logic [NB_REG_ADDR-1:0] w_dump_index;
    logic                   w_dump_valid;

    // Register 0 is never a write target, so it holds its reset value of 0.
    assign w_wr_en = i_reg_we && (i_reg_dest != '0);

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            for (int i = 0; i < c_DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else if (w_wr_en) begin
            regs_q[i_reg_dest] <= i_wb_data;
        end
    end

`ifdef REGFILE_BYPASS_EN
    assign o_rs_data = (w_wr_en && (i_reg_dest == i_rs_addr)) ? i_wb_data : regs_q[i_rs_addr];
    assign o_rt_data = (w_wr_en && (i_reg_dest == i_rt_addr)) ? i_wb_data : regs_q[i_rt_addr];
`else
    assign o_rs_data = regs_q[i_rs_addr];
    assign o_rt_data = regs_q[i_rt_addr];
`endif

    regfile_dump_ctrl #(
        .NB_REG_ADDR (NB_REG_ADDR)
    ) u_dump_ctrl (
        .i_clock      (i_clock),
        .i_reset      (i_reset),
        .i_dump_start (i_dump_start),
        .i_dump_ready (i_dump_ready),
        .o_index      (w_dump_index),
        .o_valid      (w_dump_valid),
        .o_done       (o_dump_done)
    );

    // Dump reads the stored array only; forwarding never applies here.
    assign o_dump_valid = w_dump_valid;
    assign o_dump_addr  = w_dump_index;
    assign o_dump_data  = w_dump_valid ? regs_q[w_dump_index] : '0;

endmodule : register_file

`default_nettype wire

// File: tb/tb_register_file.sv
// =====================================================================
// Module   : tb_register_file
// Desc     : Scoreboard bench for register_file: directed stimulus
//            queues expectations, a negedge monitor compares them.
// Revision : 1.0 - initial release
// =====================================================================
`default_nettype none

module tb_register_file;

    localparam int NB    = 32;
    localparam int NA    = 5;
    localparam int DEPTH = 32;

`ifdef REGFILE_BYPASS_EN
    localparam logic [31:0] c_BYP_EXP = 32'hA5A5A5A5;
`else
    localparam logic [31:0] c_BYP_EXP = 32'h00000000;
`endif

    logic          clk = 1'b0;
    logic          i_reset;
    logic [NB-1:0] i_wb_data;
    logic [NA-1:0] i_reg_dest;
    logic          i_reg_we;
    logic [NA-1:0] i_rs_addr;
    logic [NA-1:0] i_rt_addr;
    logic [NB-1:0] o_rs_data;
    logic [NB-1:0] o_rt_data;
    logic          i_dump_start;
    logic          i_dump_ready;
    logic          o_dump_valid;
    logic [NA-1:0] o_dump_addr;
    logic [NB-1:0] o_dump_data;
    logic          o_dump_done;

    always #5 clk = ~clk;

    register_file #(.NB_REG(NB), .NB_REG_ADDR(NA)) dut (
        .i_clock      (clk),
        .i_reset      (i_reset),
        .i_wb_data    (i_wb_data),
        .i_reg_dest   (i_reg_dest),
        .i_reg_we     (i_reg_we),
        .i_rs_addr    (i_rs_addr),
        .i_rt_addr    (i_rt_addr),
        .o_rs_data    (o_rs_data),
        .o_rt_data    (o_rt_data),
        .i_dump_start (i_dump_start),
        .i_dump_ready (i_dump_ready),
        .o_dump_valid (o_dump_valid),
        .o_dump_addr  (o_dump_addr),
        .o_dump_data  (o_dump_data),
        .o_dump_done  (o_dump_done)
    );

    typedef struct packed {
        logic [31:0] rs;
        logic [31:0] rt;
        logic        idle;
    } rd_exp_t;

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
    } dump_exp_t;

    rd_exp_t     rd_q[$];
    dump_exp_t   dump_q[$];
    int          done_q[$];
    logic        rd_strobe = 1'b0;
    int          n_pass  = 0;
    int          n_total = 0;
    logic [31:0] mdl [DEPTH];

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endfunction

    // Monitor: read strobe, dump words and done pulse each consume an expectation.
    always @(negedge clk) begin
        rd_exp_t   re;
        dump_exp_t de;
        if (rd_strobe) begin
            if (rd_q.size() == 0) begin
                n_total++;
                $display("FAIL rd_queue: got empty queue expected an entry");
            end else begin
                re = rd_q.pop_front();
                check("rs_data", o_rs_data, re.rs);
                check("rt_data", o_rt_data, re.rt);
                if (re.idle) begin
                    check("idle_valid", {31'b0, o_dump_valid}, 32'd0);
                    check("idle_done",  {31'b0, o_dump_done},  32'd0);
                    check("idle_addr",  {27'b0, o_dump_addr},  32'd0);
                    check("idle_data",  o_dump_data,           32'd0);
                end
            end
        end
        if (o_dump_valid !== 1'b0) begin
            if (dump_q.size() == 0) begin
                n_total++;
                $display("FAIL dump_valid: got %b expected 0", o_dump_valid);
            end else begin
                de = dump_q.pop_front();
                check("dump_addr", {27'b0, o_dump_addr}, {27'b0, de.addr});
                check("dump_data", o_dump_data, de.data);
            end
        end
        if (o_dump_done !== 1'b0) begin
            if (done_q.size() == 0) begin
                n_total++;
                $display("FAIL dump_done: got %b expected 0", o_dump_done);
            end else begin
                void'(done_q.pop_front());
                check("done_valid_low", {31'b0, o_dump_valid}, 32'd0);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        i_reset = 1'b1;
        step();
        i_reset = 1'b0;
        for (int i = 0; i < DEPTH; i++) mdl[i] = 32'd0;
    endtask

    task automatic wr(input logic [4:0] d, input logic [31:0] v);
        i_reg_we   = 1'b1;
        i_reg_dest = d;
        i_wb_data  = v;
        step();
        i_reg_we = 1'b0;
        if (d != 5'd0) mdl[d] = v;
    endtask

    task automatic rd(input logic [4:0] a, input logic [4:0] b,
                      input logic [31:0] ers, input logic [31:0] ert, input logic idle);
        i_rs_addr = a;
        i_rt_addr = b;
        rd_q.push_back({ers, ert, idle});
        rd_strobe = 1'b1;
        step();
        rd_strobe = 1'b0;
    endtask

    // mode 0: ready always high; 1: ready toggles with a write to r3 while stalled; 2: reset at addr 10
    task automatic run_dump(input int mode);
        int   idx = 0;
        int   cyc = 0;
        logic rdy;
        logic wrote = 1'b0;
        logic wr_now;
        i_dump_start = 1'b1;
        step();
        i_dump_start = 1'b0;
        while (idx < DEPTH) begin
            wr_now       = 1'b0;
            rdy          = (mode == 1) ? cyc[0] : 1'b1;
            i_dump_ready = rdy;
            i_dump_start = (mode == 1);
            if (mode == 1 && idx == 3 && !rdy && !wrote) begin
                i_reg_we   = 1'b1;
                i_reg_dest = 5'd3;
                i_wb_data  = 32'hCAFEF00D;
                wrote      = 1'b1;
                wr_now     = 1'b1;
            end
            dump_q.push_back({5'(idx), mdl[idx]});
            if (mode == 2 && idx == 10) begin
                i_reset = 1'b1;
                step();
                i_reset      = 1'b0;
                i_dump_ready = 1'b0;
                for (int i = 0; i < DEPTH; i++) mdl[i] = 32'd0;
                return;
            end
            step();
            i_reg_we = 1'b0;
            if (wr_now) mdl[3] = 32'hCAFEF00D;
            if (rdy) idx++;
            cyc++;
        end
        i_dump_start = 1'b0;
        i_dump_ready = 1'b0;
        done_q.push_back(1);
        step();
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        i_reset = 1'b0; i_wb_data = '0; i_reg_dest = '0; i_reg_we = 1'b0;
        i_rs_addr = '0; i_rt_addr = '0; i_dump_start = 1'b0; i_dump_ready = 1'b0;
        step();
        do_reset();
        do_reset();
        rd(5'd5, 5'd31, 32'd0, 32'd0, 1'b1);

        wr(5'd5, 32'hDEADBEEF);
        rd(5'd5, 5'd0, 32'hDEADBEEF, 32'd0, 1'b0);

        wr(5'd0, 32'h12345678);
        rd(5'd0, 5'd0, 32'd0, 32'd0, 1'b0);

        // Same-cycle write and read of r7
        i_reg_we = 1'b1; i_reg_dest = 5'd7; i_wb_data = 32'hA5A5A5A5;
        rd(5'd7, 5'd5, c_BYP_EXP, 32'hDEADBEEF, 1'b0);
        i_reg_we = 1'b0; mdl[7] = 32'hA5A5A5A5;
        rd(5'd7, 5'd5, 32'hA5A5A5A5, 32'hDEADBEEF, 1'b0);

        // Write coinciding with reset is discarded
        i_reg_we = 1'b1; i_reg_dest = 5'd9; i_wb_data = 32'h11111111;
        do_reset();
        i_reg_we = 1'b0;
        rd(5'd9, 5'd7, 32'd0, 32'd0, 1'b1);

        for (int n = 1; n < DEPTH; n++) wr(5'(n), 32'(n * 32'h11));
        run_dump(0);
        rd(5'd31, 5'd16, 32'h0000020F, 32'h00000110, 1'b1);

        run_dump(1);
        rd(5'd3, 5'd4, 32'hCAFEF00D, 32'h00000044, 1'b1);

        run_dump(2);
        rd(5'd3, 5'd31, 32'd0, 32'd0, 1'b1);
        run_dump(0);
        rd(5'd0, 5'd1, 32'd0, 32'd0, 1'b1);

        for (int i = 0; i < 4; i++) step();
        check("rd_queue_left",   rd_q.size(),   32'd0);
        check("dump_queue_left", dump_q.size(), 32'd0);
        check("done_queue_left", done_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_register_file

`default_nettype wire

// File: doc/register_file.md
REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 The block SHALL have parameter NB_REG, default 32, meaning register data width in bits.
REQ-002 The block SHALL have parameter NB_REG_ADDR, default 5, meaning register address width; depth is 2**NB_REG_ADDR.
REQ-003 The block SHALL have port i_clock, input, 1, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port i_reset, input, 1, synchronous active-high reset.
REQ-005 The block SHALL have port i_wb_data, input, NB_REG, write-back data from the write-back stage.
REQ-006 The block SHALL have port i_reg_dest, input, NB_REG_ADDR, write-back destination register.
REQ-007 The block SHALL have port i_reg_we, input, 1, write-back enable.
REQ-008 The block SHALL have ports i_rs_addr and i_rt_addr, input, NB_REG_ADDR, decode-stage read addresses.
REQ-009 The block SHALL have ports o_rs_data and o_rt_data, output, NB_REG, decode-stage read data.
REQ-010 The block SHALL have port i_dump_start, input, 1, debug request to stream out all registers.
REQ-011 The block SHALL have port i_dump_ready, input, 1, debug consumer accepts the current word.
REQ-012 The block SHALL have port o_dump_valid, output, 1, the current dump word is valid.
REQ-013 The block SHALL have port o_dump_addr, output, NB_REG_ADDR, index of the current dump word.
REQ-014 The block SHALL have port o_dump_data, output, NB_REG, contents of the register at o_dump_addr.
REQ-015 The block SHALL have port o_dump_done, output, 1, one-cycle pulse after the final word is accepted.

Function
REQ-016 A register SHALL be written at the rising edge when i_reg_we=1 and i_reg_dest!=0; register 0 SHALL never change and SHALL always read 0.
REQ-017 o_rs_data/o_rt_data SHALL be combinational reads of the stored registers (zero latency), subject to REQ-028.
REQ-018 The dump FSM SHALL have states IDLE, DUMP and DONE.
REQ-019 In IDLE, i_dump_start=1 SHALL move the FSM to DUMP with the index=0; i_dump_start SHALL be ignored in DUMP and DONE.
REQ-020 In DUMP, o_dump_valid=1, o_dump_addr=index and o_dump_data=stored register[index] (register 0 gives 0, no bypass).
REQ-021 In DUMP, a cycle with i_dump_ready=1 SHALL accept the word; the index SHALL increment; accepting index 2**NB_REG_ADDR-1 SHALL move the FSM to DONE with no wrap-around.
REQ-022 While o_dump_valid=1 and i_dump_ready=0, o_dump_addr SHALL hold; o_dump_data SHALL follow a write to that register from the next cycle.
REQ-023 In DONE, o_dump_done=1 for exactly one cycle, then the FSM SHALL move to IDLE; o_dump_done SHALL be 0 in every other state.
REQ-024 Write-back writes SHALL continue during a dump; there is no stall output.

Reset
REQ-025 When i_reset=1 at a rising edge, all registers SHALL clear to 0, the FSM SHALL go to IDLE and the index to 0, including mid-dump.
REQ-026 After reset, o_dump_valid=0, o_dump_done=0, o_dump_addr=0, o_dump_data=0, and o_rs_data=o_rt_data=0.
REQ-027 A write with i_reset=1 in the same cycle SHALL be discarded.

Configuration
REQ-028 With macro REGFILE_BYPASS_EN defined, a read port SHALL return i_wb_data when i_reg_we=1, i_reg_dest!=0 and i_reg_dest equals that port's address (same-cycle write-to-read forwarding).
REQ-029 Without REGFILE_BYPASS_EN, read ports SHALL return the pre-write stored value in the write cycle, and the new value from the next cycle.

Structure
REQ-030 The FSM state encodings and default widths (NB_REG, NB_REG_ADDR) SHALL live in the shared MIPS package.
REQ-031 The dump FSM SHALL be a sub-module regfile_dump_ctrl that drives index/valid/done; the storage array SHALL stay in register_file.

Verification
REQ-032 Write 0xDEADBEEF to r5, then read rs=5 next cycle -> o_rs_data=0xDEADBEEF.
REQ-033 Write 0x12345678 to r0 -> rs=0 and rt=0 read 0x00000000.
REQ-034 Write 0xA5A5A5A5 to r7 with rs=7 in the same cycle -> 0xA5A5A5A5 with REGFILE_BYPASS_EN, prior value 0x00000000 without.
REQ-035 Preload rN=N*0x11, start dump, i_dump_ready always 1 -> 32 valid words addr 0..31 with r0=0, then a single o_dump_done pulse, then IDLE.
REQ-036 Dump with i_dump_ready toggling 1/0 and a write of 0xCAFEF00D to r3 while addr=3 is stalled -> addr 3 held, data becomes 0xCAFEF00D the next cycle, no word skipped.
REQ-037 Assert i_reset at addr=10 mid-dump -> next cycle o_dump_valid=0, all registers read 0, and a new i_dump_start restarts at addr 0.
